// File: rtl/bk_sum_decomposer_if.sv
// Handshake bus for bk_sum_decomposer: {S, B} request in, interleaved {A, B} result out.
interface bk_sum_decomposer_if #(
  parameter int W = 12
) ();
  logic           in_valid;
  logic           in_ready;
  logic [W:0]     in_sum;
  logic [W-1:0]   in_addend;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_pair;
  logic           out_err;

  modport master (
    output in_valid, in_sum, in_addend, out_ready,
    input  in_ready, out_valid, out_pair, out_err
  );

  modport slave (
    input  in_valid, in_sum, in_addend, out_ready,
    output in_ready, out_valid, out_pair, out_err
  );
endinterface

// File: rtl/bk_sum_decomposer.sv
// Digit-serial A = S - B with a one-bit borrow chain; the result is emitted in the
// Brent-Kung adder's interleaved operand layout so it can be replayed into the adder.
module bk_sum_decomposer #(
  parameter int W     = 12,
  parameter int DIGIT = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  bk_sum_decomposer_if.slave bus
);
  localparam int NDIG = W / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_reg, state_next;
  logic [W-1:0]    s_sh_reg, b_sh_reg, b_reg, a_reg;
  logic            s_msb_reg, borrow_reg;
  logic [CW-1:0]   cnt_reg;
  logic [2*W-1:0]  pair_reg;
  logic            err_reg;

  logic            accept, last_digit, in_ready_c, out_valid_c;
  logic [DIGIT:0]  diff;
  logic [W-1:0]    a_next;
  logic [2*W-1:0]  pair_next;

  // Low DIGIT bits of the shifted operands are always the digit being resolved;
  // the extra top bit of diff is the outgoing borrow.
  assign diff = {1'b0, s_sh_reg[DIGIT-1:0]} - {1'b0, b_sh_reg[DIGIT-1:0]}
              - {{DIGIT{1'b0}}, borrow_reg};
  assign a_next     = {diff[DIGIT-1:0], a_reg[W-1:DIGIT]};
  assign last_digit = (cnt_reg == LAST_DIGIT);

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_interleave
      assign pair_next[2*gi]   = a_next[gi];
      assign pair_next[2*gi+1] = b_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready_c = rst_n;
        if (bus.in_valid && rst_n) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_digit) state_next = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_sh_reg   <= '0;
      b_sh_reg   <= '0;
      b_reg      <= '0;
      a_reg      <= '0;
      s_msb_reg  <= 1'b0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
      pair_reg   <= '0;
      err_reg    <= 1'b0;
    end else if (accept) begin
      s_sh_reg   <= bus.in_sum[W-1:0];
      s_msb_reg  <= bus.in_sum[W];
      b_sh_reg   <= bus.in_addend;
      b_reg      <= bus.in_addend;
      a_reg      <= '0;
      borrow_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (state_reg == RUN) begin
      s_sh_reg   <= s_sh_reg >> DIGIT;
      b_sh_reg   <= b_sh_reg >> DIGIT;
      a_reg      <= a_next;
      borrow_reg <= diff[DIGIT];
      cnt_reg    <= cnt_reg + 1'b1;
      // Result is latched once, on the step that resolves the top digit.
      if (last_digit) begin
        pair_reg <= pair_next;
        err_reg  <= s_msb_reg ^ diff[DIGIT];
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_pair  = pair_reg;
  assign bus.out_err   = err_reg;
endmodule
